// File: rtl/serial_adder_nbit.sv
// rtl/serial_adder_nbit.sv - digit-serial adder/subtractor, LSB first, DIGIT bits per clock
module serial_adder_nbit #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);

  generate
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_adder_nbit: WIDTH must be a positive multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic             c;
  logic             a_msb;
  logic             b_msb;
  logic [CW-1:0]    cnt;

  logic [DIGIT:0]   slice;
  logic [WIDTH-1:0] res_next;
  logic             last;

  // One DIGIT-wide full-adder slice; its sum digit enters the result register from the top
  always_comb begin
    slice    = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, c};
    res_next = (res >> DIGIT) | (WIDTH'(slice[DIGIT-1:0]) << (WIDTH - DIGIT));
    last     = (cnt == CW'(N - 1));
  end

  // Control FSM with datapath registers; all outputs are registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      res      <= '0;
      c        <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            // Subtraction is A + ~B + ~Cin, so invert B and the incoming carry here
            a_sh  <= A;
            b_sh  <= sub ? ~B : B;
            c     <= Cin ^ sub;
            a_msb <= A[WIDTH-1];
            b_msb <= B[WIDTH-1] ^ sub;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          c    <= slice[DIGIT];
          res  <= res_next;
          a_sh <= a_sh >> DIGIT;
          b_sh <= b_sh >> DIGIT;
          cnt  <= cnt + CW'(1);
          if (last) begin
            sum      <= res_next;
            carry    <= slice[DIGIT];
            overflow <= (a_msb == b_msb) && (res_next[WIDTH-1] != a_msb);
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= DONE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
